// File: rtl/stream_mux_rr.sv
// Registered CH:1 valid/ready stream mux with fixed-priority, round-robin or forced selection.
// Latency 1 cycle, one word per cycle; a held output word blocks every input (in_ready low) until taken.
module stream_mux_rr #(
   parameter int n    = 16,
   parameter int CH   = 4,
   parameter int MODE = 1,
   parameter int SELW = $clog2(CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CH*n-1:0]   in_data,
   input  logic [CH-1:0]     in_valid,
   output logic [CH-1:0]     in_ready,
   input  logic              force_en,
   input  logic [SELW-1:0]   force_sel,
   output logic [n-1:0]      out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SELW-1:0]   out_sel
);

   logic [1:0]      rst_q;
   logic            rst_sync_n;
   logic [CH-1:0]   elig;
   logic            any_elig;
   logic            le;
   logic            take;
   logic [SELW-1:0] gnt;
   logic [SELW-1:0] ptr;
   logic            found;
   logic [n-1:0]    sel_dat;

   // Assertion reaches the datapath asynchronously; release is retimed to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_q <= 2'b00;
      end else begin
         rst_q <= {rst_q[0], 1'b1};
      end
   end

   assign rst_sync_n = rst_q[1];

   always_comb begin
      elig = in_valid;
      if (force_en) begin
         elig = '0;
         for (int k = 0; k < CH; k++) begin
            if (force_sel == SELW'(k)) begin
               elig[k] = in_valid[k];
            end
         end
      end
   end

   assign any_elig = |elig;
   assign le       = !out_valid || out_ready;
   assign take     = le && any_elig && rst_sync_n;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      if (MODE == 0) begin
         for (int k = CH - 1; k >= 0; k--) begin
            if (elig[k]) begin
               gnt = SELW'(k);
            end
         end
      end else begin
         // Search starts one past the last winner so every requester is served in turn.
         for (int i = 1; i <= CH; i++) begin
            int idx;
            idx = (int'(ptr) + i) % CH;
            if (!found && elig[idx]) begin
               gnt   = SELW'(idx);
               found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      sel_dat  = '0;
      for (int k = 0; k < CH; k++) begin
         if (gnt == SELW'(k)) begin
            in_ready[k] = take;
            sel_dat     = in_data[k*n +: n];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= SELW'(CH - 1);
      end else if (le) begin
         if (any_elig) begin
            out_valid <= 1'b1;
            out_data  <= sel_dat;
            out_sel   <= gnt;
            if (MODE == 1 && !force_en) begin
               ptr <= gnt;
            end
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a round-robin instance (wide select) and a fixed-priority instance.
module tb_stream_mux_rr;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  in_valid;
   logic        force_en;
   logic [2:0]  force_sel;
   logic        out_ready;
   logic [15:0] d [4];
   logic [63:0] in_data;

   logic [3:0]  rr_ready;
   logic [15:0] rr_data;
   logic        rr_valid;
   logic [2:0]  rr_sel;
   logic [3:0]  fp_ready;
   logic [15:0] fp_data;
   logic        fp_valid;
   logic [1:0]  fp_sel;

   int n_tests = 0;
   int n_fail  = 0;

   assign in_data = {d[3], d[2], d[1], d[0]};

   always #5 clk = ~clk;

   stream_mux_rr #(.n(16), .CH(4), .MODE(1), .SELW(3)) u_rr (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rr_ready),
      .force_en(force_en), .force_sel(force_sel), .out_data(rr_data), .out_valid(rr_valid),
      .out_ready(out_ready), .out_sel(rr_sel)
   );

   stream_mux_rr #(.n(16), .CH(4), .MODE(0)) u_fp (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(fp_ready),
      .force_en(force_en), .force_sel(force_sel[1:0]), .out_data(fp_data), .out_valid(fp_valid),
      .out_ready(out_ready), .out_sel(fp_sel)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int w;
      rst_n = 1'b0; in_valid = '0; out_ready = 1'b0; force_en = 1'b0; force_sel = '0;
      for (int k = 0; k < 4; k++) d[k] = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(rr_valid), 0);
      chk("rst_data", 32'(rr_data), 0);
      chk("rst_sel", 32'(rr_sel), 0);

      // round-robin fairness
      for (int k = 0; k < 4; k++) d[k] = 16'(16'h1000 + k);
      in_valid = 4'hF; out_ready = 1'b1;
      #1 chk("rr_first_rdy", 32'(rr_ready), 4'b0001);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("rr_valid", 32'(rr_valid), 1);
         chk("rr_sel", 32'(rr_sel), k % 4);
         chk("rr_data", 32'(rr_data), 16'h1000 + k % 4);
      end
      in_valid = '0;
      @(negedge clk);
      chk("idle1_valid", 32'(rr_valid), 0);
      chk("idle1_data", 32'(rr_data), 16'h1001);
      chk("idle1_sel", 32'(rr_sel), 1);

      // fixed priority
      d[1] = 16'h1111; d[3] = 16'hBEEF; in_valid = 4'b1010;
      repeat (2) begin
         @(negedge clk);
         chk("fp_sel", 32'(fp_sel), 1);
         chk("fp_data", 32'(fp_data), 16'h1111);
      end
      in_valid = 4'b1000;
      @(negedge clk);
      chk("fp_drop_sel", 32'(fp_sel), 3);
      chk("fp_drop_data", 32'(fp_data), 16'hBEEF);
      chk("fp_drop_valid", 32'(fp_valid), 1);

      // backpressure
      d[0] = 16'hAAAA; in_valid = 4'b0001;
      @(negedge clk);
      chk("bp_load", 32'(rr_data), 16'hAAAA);
      d[2] = 16'h2222; in_valid = 4'b0100; out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("bp_hold_data", 32'(rr_data), 16'hAAAA);
         chk("bp_hold_valid", 32'(rr_valid), 1);
         chk("bp_hold_rdy", 32'(rr_ready), 0);
      end
      out_ready = 1'b1;
      #1 chk("bp_grant", 32'(rr_ready), 4'b0100);
      @(negedge clk);
      chk("bp_data", 32'(rr_data), 16'h2222);
      chk("bp_sel", 32'(rr_sel), 2);
      in_valid = 4'b1000;
      @(negedge clk);
      chk("pre_force_sel", 32'(rr_sel), 3);

      // forced select, then out-of-range index
      force_en = 1'b1; force_sel = 3'd2; in_valid = 4'hF;
      #1 chk("force_rdy0", 32'(rr_ready), 4'b0100);
      repeat (3) begin
         @(negedge clk);
         chk("force_sel_out", 32'(rr_sel), 2);
         chk("force_rdy", 32'(rr_ready), 4'b0100);
      end
      chk("force_ptr", 32'(u_rr.ptr), 3);
      force_sel = 3'd5;
      #1 chk("oor_rdy", 32'(rr_ready), 0);
      @(negedge clk);
      chk("oor_valid", 32'(rr_valid), 0);
      chk("oor_data", 32'(rr_data), 16'h2222);

      // wrap from ch3 to ch0
      force_en = 1'b0; in_valid = 4'b1000;
      @(negedge clk);
      chk("wrap_sel3", 32'(rr_sel), 3);
      chk("wrap_data3", 32'(rr_data), 16'hBEEF);
      in_valid = 4'b1001;
      #1 chk("wrap_rdy", 32'(rr_ready), 4'b0001);
      @(negedge clk);
      chk("wrap_sel0", 32'(rr_sel), 0);
      chk("wrap_data0", 32'(rr_data), 16'hAAAA);
      in_valid = '0;
      @(negedge clk);
      chk("idle2_valid", 32'(rr_valid), 0);
      chk("idle2_data", 32'(rr_data), 16'hAAAA);

      // reset asserted while a word is held
      in_valid = 4'b0010; out_ready = 1'b0;
      @(negedge clk);
      chk("pre_rst_valid", 32'(rr_valid), 1);
      chk("pre_rst_data", 32'(rr_data), 16'h1111);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(rr_valid), 0);
      chk("arst_data", 32'(rr_data), 0);
      chk("arst_sel", 32'(rr_sel), 0);
      out_ready = 1'b1; in_valid = 4'hF; d[0] = 16'h1000;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("rst_sync_rdy", 32'(rr_ready), 0);
      w = 0;
      while (!rr_valid && w < 10) begin
         @(negedge clk);
         w++;
      end
      chk("rel_valid", 32'(rr_valid), 1);
      chk("rel_sel", 32'(rr_sel), 0);
      chk("rel_data", 32'(rr_data), 16'h1000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Registered N-way stream multiplexer. Generalises the combinational 2:1 word select to CH channels of n-bit data.
- Uses valid/ready handshakes and selectable arbitration: fixed priority, round-robin, or software-forced select.
- Sits between the cosine datapath producers (e.g. multiple angle or term sources) and a single shared consumer.
- Provides one output register stage with full 1-word/cycle throughput.

Parameters:
- n, 16: data width per channel in bits.
- CH, 4: number of input channels, minimum 2.
- MODE, 1: arbitration mode. 0 = fixed priority (lowest index wins); 1 = round-robin.
- SELW, $clog2(CH): width of the select/index fields.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  CH*n  packed channel data; channel k occupies bits [k*n+n-1 : k*n].
- in_valid  input  CH  per-channel data valid.
- in_ready  output  CH  per-channel accept; at most one bit high per cycle.
- force_en  input  1  when 1, only channel force_sel is eligible (manual select mode).
- force_sel  input  SELW  forced channel index.
- out_data  output  n  registered selected word.
- out_valid  output  1  out_data holds an untaken word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_sel  output  SELW  index of the channel that supplied out_data.

Behaviour:
- Reset: async assert forces out_valid=0, out_data=0, out_sel=0, rr pointer ptr=CH-1 (so channel 0 wins first). Assertion mid-transfer discards the held word. Deassertion is synchronous to clk via the standard synchroniser.
- Load enable: le = !out_valid || out_ready.
- Eligible set E = in_valid, masked to bit force_sel when force_en=1. If force_sel >= CH, E = 0.
- Grant g:
  - MODE 0: lowest set index of E.
  - MODE 1: first set index searching ptr+1, ptr+2, ... mod CH (wraps from CH-1 to 0).
- in_ready[g] = le && |E. All other in_ready bits = 0. in_ready may depend combinationally on in_valid; in_valid must never depend on in_ready.
- Transfer on channel g: in_valid[g] && in_ready[g]. At the next edge: out_data <= channel g data, out_sel <= g, out_valid <= 1.
- If le and E == 0: out_valid <= 0. out_data and out_sel hold their old values.
- If !le (out_valid=1, out_ready=0): out_data, out_sel and out_valid hold; all in_ready = 0.
- Simultaneous output take and new grant: the new word loads in the same edge, giving back-to-back words with no bubble.
- Latency: exactly 1 cycle from input transfer to out_valid.
- ptr <= g on every transfer in MODE 1 when force_en=0. Forced transfers and MODE 0 leave ptr unchanged.
- force_en may change on any cycle; it takes effect on that cycle's arbitration only. It never affects a word already held in the output register.
- No data width arithmetic; data passes bit-exact.

Test Plan:
- Reset: hold rst_n=0 mid-stream with out_valid=1 -> out_valid, out_data, out_sel read 0 immediately, without a clock edge. After release, the first grant with all channels valid goes to channel 0.
- Round-robin fairness (MODE 1, CH=4): all four channels valid continuously, out_ready=1, data k=16'h1000+k -> out_sel sequence 0,1,2,3,0,1. One word per cycle, no bubbles.
- Fixed priority (MODE 0): channels 1 and 3 valid, out_ready=1 -> out_sel stays 1 while ch1 valid. When ch1 drops, ch3 word 16'hBEEF appears the next cycle.
- Backpressure: out_valid=1 with 16'hAAAA, out_ready=0 for 3 cycles, ch2 valid -> out_data holds 16'hAAAA and in_ready=0 throughout. On out_ready=1, ch2 is granted that cycle and its word appears the next cycle.
- Force mode: force_en=1, force_sel=2, all channels valid -> only in_ready[2] ever asserts and ptr is unchanged. With force_sel=3'd5 (CH=4, out-of-range) -> no grant and out_valid falls to 0.
- Wrap/idle: only ch3 then ch0 valid (MODE 1, ptr=3) -> ch0 is granted after ch3 (wrap). With all in_valid=0 and out_ready=1 -> out_valid=0 next cycle and out_data keeps its last value.
